spi_master: RTL and testbench

//  Initiator end of the team's 10-bit SPI RAM link. Takes a command + byte from
//  a host, drives ss_n/MOSI to the SPI_WRAPPER responder, and for read-data

---
 rtl/spi_pkg.sv | 31 +++
 rtl/spi_shift_reg.sv | 36 +++
 rtl/spi_master.sv | 230 +++++++++++++++++++++++
 tb/tb_spi_master.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI RAM link initiator and responder.
// Holds the command encodings, the frame geometry defaults and the
// initiator state encoding.
package spi_pkg;

  // Frame geometry defaults, shared with SPI_WRAPPER
  localparam int SPI_FRAME_W = 10;
  localparam int SPI_DATA_W  = 8;

  // Command field carried in the two MSBs of every frame
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Initiator states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    WAIT  = 3'd2,
    READ  = 3'd3,
    END   = 3'd4,
    GAP   = 3'd5
  } spiState_t;

  // Only read-data frames expect a reply byte on MISO
  function automatic logic cmdNeedsReply(input logic [1:0] cmd);
    return (cmd == CMD_RD_DATA);
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: parallel-load shift register used for both the outgoing
// frame and the incoming reply byte. Shifts towards the MSB, so the serial
// output is MSB first and serial input bits enter at bit 0.
// o_shiftNext exposes the value the register would hold after one more shift,
// which lets the caller capture a complete word on the same edge as the final
// serial bit.
module spi_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadData,
  input  logic             i_shift,
  input  logic             i_serialIn,
  output logic             o_serialOut,
  output logic [WIDTH-1:0] o_shiftNext
);

  logic [WIDTH-1:0] r_data;

  // Load has priority over shift; zero fill means the register drains to zero
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_loadData;
    end else if (i_shift) begin
      r_data <= {r_data[WIDTH-2:0], i_serialIn};
    end
  end

  assign o_serialOut = r_data[WIDTH-1];
  assign o_shiftNext = {r_data[WIDTH-2:0], i_serialIn};

endmodule

// File: rtl/spi_master.sv
// spi_master: initiator end of the 10-bit SPI RAM link.
// Sends {cmd, tx_data} MSB first on MOSI while ss_n is low, and for read-data
// frames waits TURNAROUND cycles and then collects an 8-bit reply from MISO.
// Both ends share clk, so one bit moves per clock and no SCLK is produced.
// Every output is a register whose next value is decoded from the next state,
// so ss_n/done/busy line up exactly with the state the FSM is in.
module spi_master
  import spi_pkg::*;
#(
  parameter int FRAME_W    = SPI_FRAME_W,
  parameter int DATA_W     = SPI_DATA_W,
  parameter int TURNAROUND = 1,
  parameter int IDLE_GAP   = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [1:0]        i_cmd,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_ss_n,
  output logic              o_mosi,
  input  logic              i_miso
);

  localparam int BIT_CW = $clog2(FRAME_W);
  localparam int RX_CW  = $clog2(DATA_W);
  localparam int DLY_W  = 8;

  spiState_t r_state;
  spiState_t w_nextState;

  logic [BIT_CW-1:0] r_bitCnt;
  logic [RX_CW-1:0]  r_rxCnt;
  logic [DLY_W-1:0]  r_dlyCnt;
  logic              r_isRead;

  logic              r_busy;
  logic              r_done;
  logic              r_rxValid;
  logic              r_ssN;
  logic [DATA_W-1:0] r_rxData;

  logic              w_accept;
  logic              w_gapOver;
  logic              w_txShift;
  logic              w_rxShift;
  logic              w_rxLast;
  logic              w_busyNext;
  logic              w_doneNext;
  logic              w_rxValidNext;
  logic              w_ssNNext;
  logic [DATA_W-1:0] w_rxNext;
  logic [FRAME_W-1:0] w_txNextUnused;
  logic              w_rxMsbUnused;

  // The last ss_n-high cycle of a frame: END when the gap is a single cycle,
  // otherwise the final GAP cycle. A start seen on the edge that ends this
  // cycle opens the next frame directly, so a held start yields exactly
  // IDLE_GAP ss_n-high cycles between frames.
  assign w_gapOver = ((r_state == END) && (IDLE_GAP == 1)) ||
                     ((r_state == GAP) && (r_dlyCnt == '0));

  assign w_accept  = (w_nextState == SHIFT) && (r_state != SHIFT);
  assign w_txShift = (r_state == SHIFT);
  assign w_rxShift = (r_state == READ);
  assign w_rxLast  = (r_state == READ) && (r_rxCnt == '0);

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode; start is only looked at in IDLE or at the end of the gap
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (r_bitCnt == '0) begin
          w_nextState = r_isRead ? WAIT : END;
        end
      end
      WAIT: begin
        if (r_dlyCnt == '0) begin
          w_nextState = READ;
        end
      end
      READ: begin
        if (r_rxCnt == '0) begin
          w_nextState = END;
        end
      end
      END: begin
        if (w_gapOver) begin
          w_nextState = i_start ? SHIFT : IDLE;
        end else begin
          w_nextState = GAP;
        end
      end
      GAP: begin
        if (w_gapOver) begin
          w_nextState = i_start ? SHIFT : IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode from the next state, registered below
  always_comb begin
    w_ssNNext     = 1'b1;
    w_busyNext    = 1'b0;
    w_doneNext    = 1'b0;
    w_rxValidNext = 1'b0;
    case (w_nextState)
      SHIFT, WAIT, READ: begin
        w_ssNNext  = 1'b0;
        w_busyNext = 1'b1;
      end
      END: begin
        w_busyNext    = 1'b1;
        w_doneNext    = 1'b1;
        w_rxValidNext = r_isRead;
      end
      GAP: begin
        w_busyNext = 1'b1;
      end
      default: begin
        w_busyNext = 1'b0;
      end
    endcase
  end

  // Output registers; the reply byte is captured on the edge of its last bit
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ssN     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rxValid <= 1'b0;
      r_rxData  <= '0;
    end else begin
      r_ssN     <= w_ssNNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
      r_rxValid <= w_rxValidNext;
      if (w_rxLast) begin
        r_rxData <= w_rxNext;
      end
    end
  end

  // Frame bookkeeping: bit counter, turnaround/gap delay and reply bit counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bitCnt <= '0;
      r_rxCnt  <= '0;
      r_dlyCnt <= '0;
      r_isRead <= 1'b0;
    end else begin
      if (w_accept) begin
        r_bitCnt <= BIT_CW'(FRAME_W - 1);
        r_isRead <= cmdNeedsReply(i_cmd);
      end else if ((r_state == SHIFT) && (r_bitCnt != '0)) begin
        r_bitCnt <= r_bitCnt - BIT_CW'(1);
      end

      if ((r_state == SHIFT) && (w_nextState == WAIT)) begin
        r_dlyCnt <= DLY_W'(TURNAROUND - 1);
      end else if ((r_state == END) && (w_nextState == GAP)) begin
        r_dlyCnt <= DLY_W'(IDLE_GAP - 2);
      end else if (((r_state == WAIT) || (r_state == GAP)) && (r_dlyCnt != '0)) begin
        r_dlyCnt <= r_dlyCnt - DLY_W'(1);
      end

      if ((r_state == WAIT) && (w_nextState == READ)) begin
        r_rxCnt <= RX_CW'(DATA_W - 1);
      end else if ((r_state == READ) && (r_rxCnt != '0)) begin
        r_rxCnt <= r_rxCnt - RX_CW'(1);
      end
    end
  end

  // Outgoing frame: loaded on the accepting edge, drains to zero behind the last bit
  spi_shift_reg #(
    .WIDTH(FRAME_W)
  ) u_txShift (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_accept),
    .i_loadData  ({i_cmd, i_tx_data}),
    .i_shift     (w_txShift),
    .i_serialIn  (1'b0),
    .o_serialOut (o_mosi),
    .o_shiftNext (w_txNextUnused)
  );

  // Incoming reply byte: cleared on accept, one MISO bit per READ cycle
  spi_shift_reg #(
    .WIDTH(DATA_W)
  ) u_rxShift (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_accept),
    .i_loadData  ('0),
    .i_shift     (w_rxShift),
    .i_serialIn  (i_miso),
    .o_serialOut (w_rxMsbUnused),
    .o_shiftNext (w_rxNext)
  );

  assign o_ss_n     = r_ssN;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_rx_valid = r_rxValid;
  assign o_rx_data  = r_rxData;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed test of spi_master with a small responder model.
// Sample index j is the value seen half a cycle after rising edge j, where
// edge 0 is the edge that accepts start.
module tb_spi_master;

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       start   = 1'b0;
  logic [1:0] cmd     = 2'b00;
  logic [7:0] txData  = 8'h00;
  logic       miso    = 1'b0;
  logic       busy, done, rxValid, ssN, mosi;
  logic [7:0] rxData;

  logic       start2  = 1'b0;
  logic [1:0] cmd2    = 2'b00;
  logic [7:0] txData2 = 8'h00;
  logic       busy2, done2, rxValid2, ssN2, mosi2;
  logic [7:0] rxData2;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] obsSsN, obsMosi, obsDone, obsRxValid, obsBusy;
  logic [7:0]  ram [256];
  logic [7:0]  wrAddr = 8'h00;
  logic [7:0]  rdAddr = 8'h00;

  always #5 clk = ~clk;

  spi_master dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_cmd      (cmd),
    .i_tx_data  (txData),
    .o_busy     (busy),
    .o_done     (done),
    .o_rx_data  (rxData),
    .o_rx_valid (rxValid),
    .o_ss_n     (ssN),
    .o_mosi     (mosi),
    .i_miso     (miso)
  );

  spi_master #(
    .IDLE_GAP(3)
  ) dutGap3 (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start2),
    .i_cmd      (cmd2),
    .i_tx_data  (txData2),
    .o_busy     (busy2),
    .o_done     (done2),
    .o_rx_data  (rxData2),
    .o_rx_valid (rxValid2),
    .o_ss_n     (ssN2),
    .o_mosi     (mosi2),
    .i_miso     (1'b0)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  function automatic int firstHigh(input logic [31:0] v);
    for (int i = 0; i < 32; i++) begin
      if (v[i] === 1'b1) return i;
    end
    return -1;
  endfunction

  function automatic int mosiWord();
    int w;
    w = 0;
    for (int i = 0; i < 10; i++) w = (w << 1) | int'(obsMosi[i]);
    return w;
  endfunction

  // Start one frame, record 32 samples, act as the responder on MOSI/MISO.
  // pulseA/pulseB give extra sample indices whose edge sees start high.
  task automatic applyStimulus(input logic [1:0] c, input logic [7:0] d,
                               input int pulseA, input int pulseB);
    logic [9:0] word;
    logic [7:0] reply;
    logic       replying;
    word     = '0;
    reply    = '0;
    replying = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    cmd    = c;
    txData = d;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      obsSsN[j]     = ssN;
      obsMosi[j]    = mosi;
      obsDone[j]    = done;
      obsRxValid[j] = rxValid;
      obsBusy[j]    = busy;
      start  = (j == pulseA - 1) || (j == pulseB - 1);
      cmd    = 2'(j);
      txData = 8'hFF ^ 8'(j);
      if (j < 10) word = {word[8:0], mosi};
      if (j == 9) begin
        case (word[9:8])
          2'b00: wrAddr = word[7:0];
          2'b01: ram[wrAddr] = word[7:0];
          2'b10: rdAddr = word[7:0];
          default: begin
            replying = 1'b1;
            reply    = ram[rdAddr];
          end
        endcase
      end
      miso = (replying && j >= 11 && j <= 18) ? reply[18 - j] : 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    logic sawDone;
    int   lowRun, highRun, gaps, gap1, gap2, firstLowLen;
    logic seenLow;

    foreach (ram[i]) ram[i] = 8'h00;

    // Reset values
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_ssn", ssN, 1);
    checkOutput("rst_mosi", mosi, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rxvalid", rxValid, 0);
    checkOutput("rst_rxdata", rxData, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: write address 0x05
    applyStimulus(2'b00, 8'h05, -1, -1);
    checkOutput("t1_mosi", mosiWord(), 10'h005);
    checkOutput("t1_ssLowCount", $countones(~obsSsN), 10);
    checkOutput("t1_ssRise", firstHigh(obsSsN), 10);
    checkOutput("t1_doneIdx", firstHigh(obsDone), 10);
    checkOutput("t1_doneCount", $countones(obsDone), 1);
    checkOutput("t1_rxValidCount", $countones(obsRxValid), 0);
    checkOutput("t1_busyFall", firstHigh(~obsBusy), 11);

    // 2: write data 0xAA
    applyStimulus(2'b01, 8'hAA, -1, -1);
    checkOutput("t2_mosi", mosiWord(), 10'h1AA);
    checkOutput("t2_doneIdx", firstHigh(obsDone), 10);
    checkOutput("t2_ram05", ram[8'h05], 8'hAA);

    // 3: read address 0x05 then read data
    applyStimulus(2'b10, 8'h05, -1, -1);
    checkOutput("t3_addrMosi", mosiWord(), 10'h205);
    applyStimulus(2'b11, 8'h00, -1, -1);
    checkOutput("t3_mosi", mosiWord(), 10'h300);
    checkOutput("t3_waitMosi", obsMosi[10], 0);
    checkOutput("t3_ssLowCount", $countones(~obsSsN), 19);
    checkOutput("t3_doneIdx", firstHigh(obsDone), 19);
    checkOutput("t3_rxValidIdx", firstHigh(obsRxValid), 19);
    checkOutput("t3_rxValidCount", $countones(obsRxValid), 1);
    checkOutput("t3_rxData", rxData, 8'hAA);
    checkOutput("t3_busyFall", firstHigh(~obsBusy), 20);

    // 4: start pulsed during a read-data frame is ignored
    applyStimulus(2'b11, 8'h00, 3, 15);
    checkOutput("t4_doneCount", $countones(obsDone), 1);
    checkOutput("t4_doneIdx", firstHigh(obsDone), 19);
    checkOutput("t4_busyFall", firstHigh(~obsBusy), 20);
    checkOutput("t4_ssLowCount", $countones(~obsSsN), 19);
    checkOutput("t4_rxData", rxData, 8'hAA);

    // rx_data holds across a write frame
    applyStimulus(2'b00, 8'h21, -1, -1);
    checkOutput("hold_rxData", rxData, 8'hAA);
    checkOutput("hold_rxValidCount", $countones(obsRxValid), 0);

    // 5: reset in the sixth cycle of a write-data frame
    @(negedge clk);
    start  = 1'b1;
    cmd    = 2'b01;
    txData = 8'h77;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("t5_ssnBefore", ssN, 0);
    reset = 1'b1;
    #1;
    checkOutput("t5_ssn", ssN, 1);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_mosi", mosi, 0);
    sawDone = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 sawDone = sawDone | done;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 sawDone = sawDone | done;
    end
    checkOutput("t5_noDone", sawDone, 0);
    applyStimulus(2'b01, 8'h3C, -1, -1);
    checkOutput("t5_mosi_after", mosiWord(), 10'h13C);
    checkOutput("t5_doneIdx", firstHigh(obsDone), 10);
    checkOutput("t5_ram21", ram[8'h21], 8'h3C);

    // 6: start held high with IDLE_GAP=3
    @(negedge clk);
    start2  = 1'b1;
    cmd2    = 2'b01;
    txData2 = 8'h3C;
    lowRun = 0; highRun = 0; gaps = 0; gap1 = -1; gap2 = -1;
    firstLowLen = -1; seenLow = 1'b0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (ssN2 === 1'b0) begin
        if (seenLow && highRun > 0) begin
          if (gaps == 0) gap1 = highRun;
          else if (gaps == 1) gap2 = highRun;
          gaps++;
        end
        lowRun++;
        highRun = 0;
        seenLow = 1'b1;
      end else begin
        if (lowRun > 0 && firstLowLen < 0) firstLowLen = lowRun;
        lowRun = 0;
        if (seenLow) highRun++;
      end
    end
    start2 = 1'b0;
    checkOutput("t6_frameLow", firstLowLen, 10);
    checkOutput("t6_gap1", gap1, 3);
    checkOutput("t6_gap2", gap2, 3);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
